// File: rtl/fifo_sync_cfg_if.sv
// Producer/consumer-side signal bundle of the configurable synchronous FIFO.
// The master modport belongs to the logic using the FIFO; the slave modport belongs to the FIFO.
interface fifo_sync_cfg_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   af_thresh;
    logic [ADDR_WIDTH:0]   ae_thresh;
    logic [ADDR_WIDTH:0]   fifo_count;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;
    logic [ADDR_WIDTH:0]   high_water;

    modport master (
        output wr_en, data_in, rd_en, af_thresh, ae_thresh, err_clr,
        input  data_out, full, empty, almost_full, almost_empty,
               fifo_count, overflow, underflow, high_water
    );

    modport slave (
        input  wr_en, data_in, rd_en, af_thresh, ae_thresh, err_clr,
        output data_out, full, empty, almost_full, almost_empty,
               fifo_count, overflow, underflow, high_water
    );
endinterface

// File: rtl/fifo_sync_cfg.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through reads,
// run-time almost-full/empty thresholds, sticky error flags and a high-water monitor.
module fifo_sync_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = 0,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    fifo_sync_cfg_if.slave   bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic [ADDR_WIDTH:0]   high_water_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_set;
    logic                  udf_set;

    // Accept decisions use pre-edge occupancy only; a write never bypasses to a same-cycle read.
    always_comb begin
        full       = (count == DEPTH_CNT);
        empty      = (count == '0);
        wr_acc     = bus.wr_en && !full;
        rd_acc     = bus.rd_en && !empty;
        ovf_set    = bus.wr_en && full;
        udf_set    = bus.rd_en && empty;
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + ONE_CNT;
        end else if (rd_acc && !wr_acc) begin
            count_next = count - ONE_CNT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            high_water_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            // A new error in the same cycle as err_clr wins, so the flag stays set.
            overflow_q  <= ovf_set | (overflow_q  & ~bus.err_clr);
            underflow_q <= udf_set | (underflow_q & ~bus.err_clr);
            if (bus.err_clr || (count_next > high_water_q)) begin
                high_water_q <= count_next;
            end
        end
    end

    // NOTE: the storage array is deliberately left out of reset; the pointers and
    // count define which words are valid, and a resettable array would not map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign bus.data_out = dout_q;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= bus.af_thresh);
    assign bus.almost_empty = (count <= bus.ae_thresh);
    assign bus.fifo_count   = count;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.high_water   = high_water_q;
endmodule
